mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline control stage and a single-port word RAM.
// Handles byte/half/word alignment, lane steering, load extension and misalignment faults.
module mem_access_unit #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    output logic                 req_ready,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 misalign,
    output logic                 ram_en,
    output logic [3:0]           ram_we,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [31:0]          ram_wdata,
    input  logic [31:0]          ram_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] stb;
        case (size)
            SZ_BYTE: stb = 4'b0001 << off;
            SZ_HALF: stb = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: stb = 4'b1111;
            default: stb = 4'b0000;
        endcase
        return stb;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{wdata[7:0]}};
            SZ_HALF: d = {2{wdata[15:0]}};
            SZ_WORD: d = wdata;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        uns,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] d;
        case (off)
            2'b00:   b = rdata[7:0];
            2'b01:   b = rdata[15:8];
            2'b10:   b = rdata[23:16];
            2'b11:   b = rdata[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: d = uns ? {24'h00_0000, b} : {{24{b[7]}}, b};
            SZ_HALF: d = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            SZ_WORD: d = rdata;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    logic [1:0]           state_r;
    logic [1:0]           state_nxt_s;
    logic                 req_ready_r;
    logic                 resp_valid_r;
    logic [31:0]          resp_rdata_r;
    logic                 misalign_r;
    logic                 ram_en_r;
    logic [3:0]           ram_we_r;
    logic [ADDR_BITS-1:0] ram_addr_r;
    logic [31:0]          ram_wdata_r;

    logic                 we_r;
    logic [1:0]           off_r;
    logic [1:0]           size_r;
    logic                 uns_r;

    logic                 accept_s;
    logic                 bad_s;
    logic                 addr_unused_s;

    assign accept_s      = req_valid && req_ready_r;
    assign bad_s         = is_misaligned(req_size, req_addr[1:0]);
    // Address bits above the RAM window are dropped so accesses wrap.
    assign addr_unused_s = ^req_addr[31:ADDR_BITS+2];

    // Next-state decode for the request sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = bad_s ? ST_RESP : ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = we_r ? ST_RESP : ST_WAIT;
            ST_WAIT:  state_nxt_s = ST_RESP;
            ST_RESP:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State, captured request fields and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            misalign_r   <= 1'b0;
            ram_en_r     <= 1'b0;
            ram_we_r     <= 4'b0000;
            ram_addr_r   <= '0;
            ram_wdata_r  <= 32'h0000_0000;
            we_r         <= 1'b0;
            off_r        <= 2'b00;
            size_r       <= 2'b00;
            uns_r        <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            req_ready_r  <= (state_nxt_s == ST_IDLE);
            resp_valid_r <= (state_nxt_s == ST_RESP);
            ram_en_r     <= (state_nxt_s == ST_ISSUE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        we_r       <= req_we;
                        off_r      <= req_addr[1:0];
                        size_r     <= req_size;
                        uns_r      <= req_unsigned;
                        misalign_r <= bad_s;
                        if (!bad_s) begin
                            ram_addr_r <= req_addr[ADDR_BITS+1:2];
                        end
                        ram_we_r    <= (req_we && !bad_s) ? store_strobe(req_size, req_addr[1:0]) : 4'b0000;
                        ram_wdata_r <= (req_we && !bad_s) ? store_data(req_size, req_wdata) : 32'h0000_0000;
                        if (bad_s) begin
                            resp_rdata_r <= 32'h0000_0000;
                        end
                    end
                end
                ST_ISSUE: begin
                    ram_we_r <= 4'b0000;
                    if (we_r) begin
                        resp_rdata_r <= 32'h0000_0000;
                    end
                end
                ST_WAIT: begin
                    resp_rdata_r <= load_extend(size_r, off_r, uns_r, ram_rdata);
                end
                ST_RESP: begin
                    misalign_r <= 1'b0;
                end
                default: begin
                    ram_we_r <= 4'b0000;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign misalign   = misalign_r;
    assign ram_en     = ram_en_r;
    assign ram_we     = ram_we_r;
    assign ram_addr   = ram_addr_r;
    assign ram_wdata  = ram_wdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-write word RAM model.
module tb_mem_access_unit;

    localparam int AB = 12;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_we;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic          req_ready;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          misalign;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AB-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic [31:0]   mem [0:(1<<AB)-1];
    int            tests;
    int            fails;

    mem_access_unit #(.ADDR_BITS(AB)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .misalign     (misalign),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: per-lane writes, read data one cycle after a read strobe.
    always @(posedge clk) begin
        if (ram_en) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
            if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic uns);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic [3:0] exp_we,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_addr);
        issue(tag, 1'b1, addr, wdata, size, 1'b0);
        check({tag, "_ram_en"}, {31'h0, ram_en}, 32'h1);
        check({tag, "_ram_we"}, {28'h0, ram_we}, {28'h0, exp_we});
        check({tag, "_ram_addr"}, {20'h0, ram_addr}, exp_addr);
        check({tag, "_ram_wdata"}, ram_wdata, exp_wdata);
        check({tag, "_early_resp"}, {31'h0, resp_valid}, 32'h0);
        step();
        check({tag, "_resp"}, {31'h0, resp_valid}, 32'h1);
        check({tag, "_misalign"}, {31'h0, misalign}, 32'h0);
        check({tag, "_rdata0"}, resp_rdata, 32'h0);
        check({tag, "_ram_en_off"}, {31'h0, ram_en}, 32'h0);
        step();
        check({tag, "_resp_pulse"}, {31'h0, resp_valid}, 32'h0);
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] exp_addr, input logic [31:0] exp_data);
        issue(tag, 1'b0, addr, 32'h0, size, uns);
        check({tag, "_ram_en"}, {31'h0, ram_en}, 32'h1);
        check({tag, "_ram_we"}, {28'h0, ram_we}, 32'h0);
        check({tag, "_ram_addr"}, {20'h0, ram_addr}, exp_addr);
        step();
        check({tag, "_wait_resp"}, {31'h0, resp_valid}, 32'h0);
        check({tag, "_wait_en"}, {31'h0, ram_en}, 32'h0);
        step();
        check({tag, "_resp"}, {31'h0, resp_valid}, 32'h1);
        check({tag, "_rdata"}, resp_rdata, exp_data);
        check({tag, "_misalign"}, {31'h0, misalign}, 32'h0);
        step();
        check({tag, "_resp_pulse"}, {31'h0, resp_valid}, 32'h0);
    endtask

    task automatic do_fault(input string tag, input logic we, input logic [31:0] addr,
                            input logic [1:0] size);
        issue(tag, we, addr, 32'hFFFF_FFFF, size, 1'b0);
        check({tag, "_resp"}, {31'h0, resp_valid}, 32'h1);
        check({tag, "_misalign"}, {31'h0, misalign}, 32'h1);
        check({tag, "_rdata0"}, resp_rdata, 32'h0);
        check({tag, "_ram_en"}, {31'h0, ram_en}, 32'h0);
        step();
        check({tag, "_resp_pulse"}, {31'h0, resp_valid}, 32'h0);
        check({tag, "_ram_en2"}, {31'h0, ram_en}, 32'h0);
        check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        for (int i = 0; i < (1 << AB); i++) mem[i] = 32'h0;
        ram_rdata = 32'h0;
    end

    initial begin
        tests        = 0;
        fails        = 0;
        clk          = 1'b0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        step();
        step();
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_misalign", {31'h0, misalign}, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_ram_en", {31'h0, ram_en}, 32'h0);
        check("rst_ram_we", {28'h0, ram_we}, 32'h0);
        check("rst_ram_addr", {20'h0, ram_addr}, 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        rst = 1'b0;
        step();
        check("post_rst_ready", {31'h0, req_ready}, 32'h1);

        do_store("sw10", 32'h10, 32'hDEAD_BEEF, 2'b10, 4'b1111, 32'hDEAD_BEEF, 32'h4);
        do_load("lw10", 32'h10, 2'b10, 1'b0, 32'h4, 32'hDEAD_BEEF);
        do_store("sb13", 32'h13, 32'h0000_00A5, 2'b00, 4'b1000, 32'hA5A5_A5A5, 32'h4);
        do_load("lb13", 32'h13, 2'b00, 1'b0, 32'h4, 32'hFFFF_FFA5);
        do_load("lbu13", 32'h13, 2'b00, 1'b1, 32'h4, 32'h0000_00A5);
        do_load("lbu11", 32'h11, 2'b00, 1'b1, 32'h4, 32'h0000_00BE);
        do_store("sw10b", 32'h10, 32'h8001_1234, 2'b10, 4'b1111, 32'h8001_1234, 32'h4);
        do_load("lh12", 32'h12, 2'b01, 1'b0, 32'h4, 32'hFFFF_8001);
        do_load("lhu12", 32'h12, 2'b01, 1'b1, 32'h4, 32'h0000_8001);
        do_load("lh10", 32'h10, 2'b01, 1'b0, 32'h4, 32'h0000_1234);
        do_store("sh16", 32'h16, 32'h1234_BEEF, 2'b01, 4'b1100, 32'hBEEF_BEEF, 32'h5);
        do_store("sw_wrap", 32'h4020, 32'h1234_5678, 2'b10, 4'b1111, 32'h1234_5678, 32'h8);
        do_load("lw20", 32'h20, 2'b10, 1'b0, 32'h8, 32'h1234_5678);

        do_fault("lw11", 1'b0, 32'h11, 2'b10);
        do_load("lw10c", 32'h10, 2'b10, 1'b0, 32'h4, 32'h8001_1234);
        do_fault("sz11", 1'b0, 32'h10, 2'b11);
        do_fault("sh15", 1'b1, 32'h15, 2'b01);
        do_load("lw14", 32'h14, 2'b10, 1'b0, 32'h5, 32'hBEEF_0000);
        check("sh15_mem_intact", mem[5], 32'hBEEF_0000);

        // Reset while the load waits for RAM data.
        issue("rst_wait", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        step();
        check("rst_wait_noresp", {31'h0, resp_valid}, 32'h0);
        rst = 1'b1;
        step();
        check("rstw_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rstw_rdata", resp_rdata, 32'h0);
        check("rstw_misalign", {31'h0, misalign}, 32'h0);
        check("rstw_ram_en", {31'h0, ram_en}, 32'h0);
        check("rstw_ram_we", {28'h0, ram_we}, 32'h0);
        check("rstw_ram_addr", {20'h0, ram_addr}, 32'h0);
        check("rstw_ram_wdata", ram_wdata, 32'h0);
        rst = 1'b0;
        step();
        check("rstw_ready", {31'h0, req_ready}, 32'h1);
        check("rstw_noresp1", {31'h0, resp_valid}, 32'h0);
        step();
        check("rstw_noresp2", {31'h0, resp_valid}, 32'h0);

        // Back-to-back loads with req_valid held high.
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_addr     = 32'h10;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        check("b2b_ready_a", {31'h0, req_ready}, 32'h1);
        step();
        check("b2b_ready_a1", {31'h0, req_ready}, 32'h0);
        check("b2b_addr_a1", {20'h0, ram_addr}, 32'h4);
        req_addr = 32'h14;
        step();
        check("b2b_ready_a2", {31'h0, req_ready}, 32'h0);
        step();
        check("b2b_ready_a3", {31'h0, req_ready}, 32'h0);
        check("b2b_resp_a3", {31'h0, resp_valid}, 32'h1);
        check("b2b_rdata_a3", resp_rdata, 32'h8001_1234);
        step();
        check("b2b_ready_a4", {31'h0, req_ready}, 32'h1);
        check("b2b_noresp_a4", {31'h0, resp_valid}, 32'h0);
        step();
        req_valid = 1'b0;
        check("b2b_en_a5", {31'h0, ram_en}, 32'h1);
        check("b2b_addr_a5", {20'h0, ram_addr}, 32'h5);
        check("b2b_hold_a5", resp_rdata, 32'h8001_1234);
        step();
        check("b2b_noresp_a6", {31'h0, resp_valid}, 32'h0);
        step();
        check("b2b_resp_a7", {31'h0, resp_valid}, 32'h1);
        check("b2b_rdata_a7", resp_rdata, 32'hBEEF_0000);
        step();
        check("b2b_ready_end", {31'h0, req_ready}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
